ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter: sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xFF reset) over the same open-collector ps2_clock/ps2_data pins that PS2_Interface receives on.
- Drives the lines only through active-high pull-low enables; the top level ties each pin to oe ? 1'b0 : 1'bz.
- Exposes busy so the receive path can ignore traffic while a command is in flight.

---
 rtl/ps2_host_tx.sv | 191 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, issues a start
// bit, shifts a byte out on device clock falls, then checks the device ACK.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 6000,
  parameter int unsigned SETUP_CYCLES   = 100,
  parameter int unsigned FIRST_TIMEOUT  = 750000,
  parameter int unsigned BIT_TIMEOUT    = 100000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       send_req,
  input  logic [7:0] send_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       tx_error
);

  localparam logic [19:0] INHIBIT_LOAD = 20'(INHIBIT_CYCLES - 1);
  localparam logic [19:0] SETUP_LOAD   = 20'(SETUP_CYCLES - 1);
  localparam logic [19:0] FIRST_LOAD   = 20'(FIRST_TIMEOUT - 1);
  localparam logic [19:0] BIT_LOAD     = 20'(BIT_TIMEOUT - 1);
  localparam logic [3:0]  LAST_BIT     = 4'd9;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    SHIFT,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t      state_reg, state_next;
  logic [9:0]  shift_reg, shift_next;
  logic [3:0]  bit_idx_reg, bit_idx_next;
  logic [19:0] count_reg, count_next;
  logic        clk_oe_reg, clk_oe_next;
  logic        data_oe_reg, data_oe_next;
  logic        done_reg, done_next;
  logic        tx_error_reg, tx_error_next;

  logic [1:0]  clk_sync_reg;
  logic [1:0]  data_sync_reg;
  logic        clk_prev_reg;

  logic        clk_s;
  logic        data_s;
  logic        fall;
  logic        expired;

  assign clk_s   = clk_sync_reg[1];
  assign data_s  = data_sync_reg[1];
  assign fall    = clk_prev_reg & ~clk_s;
  assign expired = (count_reg == 20'd0);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_sync_reg  <= 2'b00;
      data_sync_reg <= 2'b00;
      clk_prev_reg  <= 1'b0;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], ps2_clk_in};
      data_sync_reg <= {data_sync_reg[0], ps2_data_in};
      clk_prev_reg  <= clk_s;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      shift_reg    <= 10'd0;
      bit_idx_reg  <= 4'd0;
      count_reg    <= 20'd0;
      clk_oe_reg   <= 1'b0;
      data_oe_reg  <= 1'b0;
      done_reg     <= 1'b0;
      tx_error_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      bit_idx_reg  <= bit_idx_next;
      count_reg    <= count_next;
      clk_oe_reg   <= clk_oe_next;
      data_oe_reg  <= data_oe_next;
      done_reg     <= done_next;
      tx_error_reg <= tx_error_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    bit_idx_next  = bit_idx_reg;
    count_next    = expired ? 20'd0 : count_reg - 20'd1;
    clk_oe_next   = clk_oe_reg;
    data_oe_next  = data_oe_reg;
    done_next     = 1'b0;
    tx_error_next = tx_error_reg;

    case (state_reg)
      IDLE: begin
        clk_oe_next  = 1'b0;
        data_oe_next = 1'b0;
        if (send_req) begin
          shift_next    = {1'b1, ~^send_data, send_data};
          tx_error_next = 1'b0;
          count_next    = INHIBIT_LOAD;
          clk_oe_next   = 1'b1;
          state_next    = INHIBIT;
        end
      end

      INHIBIT: begin
        if (expired) begin
          data_oe_next = 1'b1;
          count_next   = SETUP_LOAD;
          state_next   = START;
        end
      end

      START: begin
        // Start bit stays on the line while the clock is handed to the device.
        if (expired) begin
          clk_oe_next  = 1'b0;
          bit_idx_next = 4'd0;
          count_next   = FIRST_LOAD;
          state_next   = SHIFT;
        end
      end

      SHIFT: begin
        if (fall) begin
          data_oe_next = ~shift_reg[bit_idx_reg];
          bit_idx_next = bit_idx_reg + 4'd1;
          count_next   = BIT_LOAD;
          if (bit_idx_reg == LAST_BIT) begin
            state_next = ACK;
          end
        end else if (expired) begin
          clk_oe_next   = 1'b0;
          data_oe_next  = 1'b0;
          tx_error_next = 1'b1;
          done_next     = 1'b1;
          state_next    = IDLE;
        end
      end

      ACK: begin
        if (fall) begin
          tx_error_next = data_s;
          count_next    = BIT_LOAD;
          state_next    = WAIT_IDLE;
        end else if (expired) begin
          clk_oe_next   = 1'b0;
          data_oe_next  = 1'b0;
          tx_error_next = 1'b1;
          done_next     = 1'b1;
          state_next    = IDLE;
        end
      end

      WAIT_IDLE: begin
        if (clk_s && data_s) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end else if (expired) begin
          tx_error_next = 1'b1;
          done_next     = 1'b1;
          state_next    = IDLE;
        end
      end

      default: begin
        clk_oe_next  = 1'b0;
        data_oe_next = 1'b0;
        state_next   = IDLE;
      end
    endcase
  end

  assign ps2_clk_oe  = clk_oe_reg;
  assign ps2_data_oe = data_oe_reg;
  assign busy        = (state_reg != IDLE);
  assign done        = done_reg;
  assign tx_error    = tx_error_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model drives the open-collector bus;
// a scoreboard queue holds the expected outcome of each command.
module tb_ps2_host_tx;

  localparam int INH   = 20;
  localparam int SETC  = 4;
  localparam int FIRST = 200;
  localparam int BITT  = 50;

  localparam int M_ACK   = 0;
  localparam int M_NACK  = 1;
  localparam int M_NOCLK = 2;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       send_req = 1'b0;
  logic [7:0] send_data = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_pin;
  logic       ps2_data_pin;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       done;
  logic       tx_error;

  // Wired-AND bus: either side may pull a line low.
  assign ps2_clk_pin  = ~ps2_clk_oe & dev_clk;
  assign ps2_data_pin = ~ps2_data_oe & dev_data;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .SETUP_CYCLES  (SETC),
    .FIRST_TIMEOUT (FIRST),
    .BIT_TIMEOUT   (BITT)
  ) dut (
    .clock      (clk),
    .resetn     (resetn),
    .send_req   (send_req),
    .send_data  (send_data),
    .ps2_clk_in (ps2_clk_pin),
    .ps2_data_in(ps2_data_pin),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .done       (done),
    .tx_error   (tx_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       err;
    logic [9:0] frame;
    bit         chk_frame;
    int         rel_to_done;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [9:0] frame_cap = 10'd0;
  int         tests = 0;
  int         fails = 0;
  int         cycle = 0;
  int         rel_cycle = 0;
  int         hi_cnt = 0;
  logic       prev_clk_oe = 1'b0;
  logic       last_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    cycle++;
    if (!resetn) begin
      hi_cnt      = 0;
      prev_clk_oe = 1'b0;
    end else begin
      if (ps2_clk_oe) hi_cnt++;
      if (prev_clk_oe && !ps2_clk_oe) rel_cycle = cycle;
      prev_clk_oe = ps2_clk_oe;
      if (done) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done=1, expected no pending command");
        end else begin
          mon_e = sb.pop_front();
          check("tx_error", 32'(tx_error), 32'(mon_e.err));
          check("clk_oe_high_cycles", 32'(hi_cnt), 32'(INH + SETC));
          check("busy_at_done", 32'(busy), 32'd0);
          check("lines_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
          if (mon_e.chk_frame)
            check("frame_bits", 32'(frame_cap), 32'(mon_e.frame));
          if (mon_e.rel_to_done >= 0)
            check("timeout_latency", 32'(cycle - rel_cycle), 32'(mon_e.rel_to_done));
        end
        hi_cnt = 0;
      end
    end
  end

  task automatic run_tx(input logic [7:0] d, input int mode, input bit second_req,
                        input bit reset6);
    exp_t e;
    int   t;
    int   half;
    logic par;
    par           = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    e.err         = (mode != M_ACK);
    e.frame       = {1'b1, par, d};
    e.chk_frame   = (mode != M_NOCLK);
    e.rel_to_done = (mode == M_NOCLK) ? FIRST : -1;

    check("err_held", 32'(tx_error), 32'(last_err));
    if (!reset6) begin
      sb.push_back(e);
      last_err = e.err;
    end
    frame_cap = 10'd0;

    @(negedge clk);
    send_data = d;
    send_req  = 1'b1;
    @(negedge clk);
    send_req  = 1'b0;

    t = 0;
    while (ps2_clk_oe && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("release_seen", 32'(t < 2000), 32'd1);
    check("start_bit", 32'(ps2_data_oe), 32'd1);

    if (mode != M_NOCLK) begin
      wait_cycles($urandom_range(5, 30));
      for (int k = 1; k <= 11; k++) begin
        half    = $urandom_range(15, 22);
        dev_clk = 1'b0;
        if (reset6 && k == 6) begin
          wait_cycles(5);
          check("pre_reset_data_oe", 32'(ps2_data_oe), 32'd1);
          check("pre_reset_busy", 32'(busy), 32'd1);
          #2 resetn = 1'b0;
          #1;
          check("async_reset_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
          check("async_reset_busy", 32'(busy), 32'd0);
          dev_clk  = 1'b1;
          dev_data = 1'b1;
          wait_cycles(3);
          resetn   = 1'b1;
          last_err = 1'b0;
          wait_cycles(5);
          return;
        end
        if (second_req && k == 5) begin
          @(negedge clk);
          send_data = ~d;
          send_req  = 1'b1;
          @(negedge clk);
          send_req  = 1'b0;
          wait_cycles(half - 2);
        end else begin
          wait_cycles(half);
        end
        if (k <= 10) frame_cap[k-1] = ps2_data_pin;
        dev_clk = 1'b1;
        if (k == 10) begin
          wait_cycles(5);
          if (mode == M_ACK) dev_data = 1'b0;
          wait_cycles(half - 5);
        end else if (k == 11) begin
          wait_cycles(5);
          dev_data = 1'b1;
        end else begin
          wait_cycles(half);
        end
      end
    end

    t = 0;
    while (busy && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("transfer_ends", 32'(t < 1000), 32'd1);
    wait_cycles(3);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, expected run to complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    int         r;
    wait_cycles(3);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_tx_error", 32'(tx_error), 32'd0);
    check("reset_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    resetn = 1'b1;
    wait_cycles(5);

    run_tx(8'hED, M_ACK, 1'b0, 1'b0);
    run_tx(8'h00, M_ACK, 1'b0, 1'b0);
    run_tx(8'h01, M_ACK, 1'b0, 1'b0);
    run_tx(8'($urandom), M_NOCLK, 1'b0, 1'b0);
    run_tx(8'($urandom), M_NACK, 1'b0, 1'b0);
    run_tx(8'h5A, M_ACK, 1'b1, 1'b0);
    run_tx(8'h1C, M_ACK, 1'b1, 1'b1);
    run_tx(8'hA5, M_ACK, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      r = $urandom_range(0, 5);
      run_tx(d, (r <= 3) ? M_ACK : ((r == 4) ? M_NACK : M_NOCLK), 1'b0, 1'b0);
    end

    wait_cycles(5);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
